// File: rtl/l2_coh_out_serializer.sv
// l2_coh_out_serializer
// Merges the L2 outgoing coherence request and response channels into one
// word-wide flit stream. Each accepted message is buffered once and emitted
// as a header flit followed by zero or WORDS_PER_LINE data flits.
// Responses have fixed priority over requests.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   l2_req_out_*       request channel (valid/ready + coh_msg, hprot, addr, line)
//   l2_rsp_out_*       response channel (valid/ready + coh_msg, req_id, to_req, addr, line)
//   noc_out_*          flit stream (valid/ready, data, last)
module l2_coh_out_serializer #(
  parameter int          LINE_ADDR_BITS = 28,
  parameter int          WORD_BITS      = 64,
  parameter int          WORDS_PER_LINE = 2,
  parameter int          CACHE_ID_BITS  = 4,
  parameter logic [1:0]  REQ_DATA_MSG   = 2'b11,
  parameter logic [1:0]  RSP_NODATA_MSG = 2'b10,
  localparam int         LINE_BITS      = WORD_BITS * WORDS_PER_LINE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      l2_req_out_valid,
  input  logic [1:0]                l2_req_out_data_coh_msg,
  input  logic [1:0]                l2_req_out_data_hprot,
  input  logic [LINE_ADDR_BITS-1:0] l2_req_out_data_addr,
  input  logic [LINE_BITS-1:0]      l2_req_out_data_line,
  output logic                      l2_req_out_ready,
  input  logic                      l2_rsp_out_valid,
  input  logic [1:0]                l2_rsp_out_data_coh_msg,
  input  logic [CACHE_ID_BITS-1:0]  l2_rsp_out_data_req_id,
  input  logic [1:0]                l2_rsp_out_data_to_req,
  input  logic [LINE_ADDR_BITS-1:0] l2_rsp_out_data_addr,
  input  logic [LINE_BITS-1:0]      l2_rsp_out_data_line,
  output logic                      l2_rsp_out_ready,
  output logic                      noc_out_valid,
  output logic [WORD_BITS-1:0]      noc_out_data,
  output logic                      noc_out_last,
  input  logic                      noc_out_ready
);

  localparam int IDXW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t               state;
  logic [IDXW-1:0]      widx;
  logic                 has_data_q;
  logic [WORD_BITS-1:0] hdr_q;
  logic [WORD_BITS-1:0] words_q [WORDS_PER_LINE];

  logic                 busy;
  logic                 fire_last;
  logic                 window;
  logic                 take_rsp;
  logic                 take_req;
  logic                 take;
  logic                 has_data_next;
  logic [WORD_BITS-1:0] hdr_next;
  logic [LINE_BITS-1:0] line_sel;

  always_comb begin
    busy          = (state != IDLE);
    noc_out_valid = busy && !rst;
    noc_out_data  = '0;
    noc_out_last  = 1'b0;
    if (noc_out_valid) begin
      if (state == HDR) begin
        noc_out_data = hdr_q;
        noc_out_last = !has_data_q;
      end else begin
        noc_out_data = words_q[widx];
        noc_out_last = (widx == LAST_IDX);
      end
    end
    // Capture of the next message overlaps the final flit of the current one.
    fire_last        = noc_out_valid && noc_out_ready && noc_out_last;
    window           = !rst && (!busy || fire_last);
    l2_rsp_out_ready = window;
    l2_req_out_ready = window && !l2_rsp_out_valid;
    take_rsp         = l2_rsp_out_valid && window;
    take_req         = l2_req_out_valid && l2_req_out_ready;
    take             = take_rsp || take_req;
  end

  always_comb begin
    hdr_next = '0;
    if (take_rsp) begin
      hdr_next[1:0]                  = l2_rsp_out_data_coh_msg;
      hdr_next[3:2]                  = l2_rsp_out_data_to_req;
      hdr_next[4]                    = 1'b1;
      hdr_next[4+CACHE_ID_BITS:5]    = l2_rsp_out_data_req_id;
      hdr_next[8+LINE_ADDR_BITS:9]   = l2_rsp_out_data_addr;
      has_data_next                  = (l2_rsp_out_data_coh_msg != RSP_NODATA_MSG);
      line_sel                       = l2_rsp_out_data_line;
    end else begin
      hdr_next[1:0]                  = l2_req_out_data_coh_msg;
      hdr_next[3:2]                  = l2_req_out_data_hprot;
      hdr_next[8+LINE_ADDR_BITS:9]   = l2_req_out_data_addr;
      has_data_next                  = (l2_req_out_data_coh_msg == REQ_DATA_MSG);
      line_sel                       = l2_req_out_data_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      widx       <= '0;
      has_data_q <= 1'b0;
      hdr_q      <= '0;
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (take) state <= HDR;
        HDR: begin
          if (noc_out_ready) begin
            if (has_data_q) begin
              state <= DATA;
              widx  <= '0;
            end else begin
              state <= take ? HDR : IDLE;
            end
          end
        end
        DATA: begin
          if (noc_out_ready) begin
            if (widx == LAST_IDX) begin
              widx  <= '0;
              state <= take ? HDR : IDLE;
            end else begin
              widx <= widx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (take) begin
        hdr_q      <= hdr_next;
        has_data_q <= has_data_next;
        widx       <= '0;
        for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
          words_q[i] <= line_sel[i*WORD_BITS +: WORD_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_coh_out_serializer.sv
module tb_l2_coh_out_serializer;

  localparam int LAB = 28;
  localparam int WB  = 64;
  localparam int WPL = 2;
  localparam int CIB = 4;
  localparam int LB  = WB * WPL;

  logic           clk;
  logic           rst;
  logic           l2_req_out_valid;
  logic [1:0]     l2_req_out_data_coh_msg;
  logic [1:0]     l2_req_out_data_hprot;
  logic [LAB-1:0] l2_req_out_data_addr;
  logic [LB-1:0]  l2_req_out_data_line;
  logic           l2_req_out_ready;
  logic           l2_rsp_out_valid;
  logic [1:0]     l2_rsp_out_data_coh_msg;
  logic [CIB-1:0] l2_rsp_out_data_req_id;
  logic [1:0]     l2_rsp_out_data_to_req;
  logic [LAB-1:0] l2_rsp_out_data_addr;
  logic [LB-1:0]  l2_rsp_out_data_line;
  logic           l2_rsp_out_ready;
  logic           noc_out_valid;
  logic [WB-1:0]  noc_out_data;
  logic           noc_out_last;
  logic           noc_out_ready;

  l2_coh_out_serializer #(
    .LINE_ADDR_BITS(LAB),
    .WORD_BITS(WB),
    .WORDS_PER_LINE(WPL),
    .CACHE_ID_BITS(CIB),
    .REQ_DATA_MSG(2'b11),
    .RSP_NODATA_MSG(2'b10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .l2_req_out_valid(l2_req_out_valid),
    .l2_req_out_data_coh_msg(l2_req_out_data_coh_msg),
    .l2_req_out_data_hprot(l2_req_out_data_hprot),
    .l2_req_out_data_addr(l2_req_out_data_addr),
    .l2_req_out_data_line(l2_req_out_data_line),
    .l2_req_out_ready(l2_req_out_ready),
    .l2_rsp_out_valid(l2_rsp_out_valid),
    .l2_rsp_out_data_coh_msg(l2_rsp_out_data_coh_msg),
    .l2_rsp_out_data_req_id(l2_rsp_out_data_req_id),
    .l2_rsp_out_data_to_req(l2_rsp_out_data_to_req),
    .l2_rsp_out_data_addr(l2_rsp_out_data_addr),
    .l2_rsp_out_data_line(l2_rsp_out_data_line),
    .l2_rsp_out_ready(l2_rsp_out_ready),
    .noc_out_valid(noc_out_valid),
    .noc_out_data(noc_out_data),
    .noc_out_last(noc_out_last),
    .noc_out_ready(noc_out_ready)
  );

  typedef struct {
    bit             is_rsp;
    logic [1:0]     coh;
    logic [1:0]     f2;
    logic [CIB-1:0] id;
    logic [LAB-1:0] addr;
    logic [LB-1:0]  line;
  } msg_t;

  typedef struct {
    logic [WB-1:0] data;
    bit            last;
  } flit_t;

  typedef struct {
    msg_t m;
    int   nflits;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  msg_t  req_q[$];
  msg_t  rsp_q[$];
  flit_t exp_q[$];
  msg_t  cur_req, cur_rsp;
  bit    req_acc = 0, rsp_acc = 0;
  int    flits_seen = 0;
  bit    count_en = 0;
  int    vcycles = 0, pulses = 0, first_cyc = -1, last_cyc = -1, cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [WB-1:0] exp_hdr(msg_t m);
    logic [WB-1:0] idf;
    idf = m.is_rsp ? WB'(m.id) : '0;
    return (WB'(m.addr) << 9) | (idf << 5) | (WB'(m.is_rsp) << 4) | (WB'(m.f2) << 2) | WB'(m.coh);
  endfunction

  function automatic bit exp_has_data(msg_t m);
    return m.is_rsp ? (m.coh != 2'b10) : (m.coh == 2'b11);
  endfunction

  task automatic push_flits(input msg_t m);
    flit_t f;
    f.data = exp_hdr(m);
    f.last = !exp_has_data(m);
    exp_q.push_back(f);
    if (exp_has_data(m)) begin
      for (int i = 0; i < WPL; i++) begin
        f.data = m.line[i*WB +: WB];
        f.last = (i == WPL - 1);
        exp_q.push_back(f);
      end
    end
  endtask

  function automatic msg_t mk(bit r, logic [1:0] c, logic [1:0] f2, logic [CIB-1:0] id,
                              logic [LAB-1:0] a, logic [LB-1:0] line);
    msg_t m;
    m.is_rsp = r; m.coh = c; m.f2 = f2; m.id = id; m.addr = a; m.line = line;
    return m;
  endfunction

  function automatic logic [LB-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: presents queue heads; fields are scrambled when idle or after acceptance.
  initial begin
    l2_req_out_valid = 1'b0;
    l2_rsp_out_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_acc) begin void'(rsp_q.pop_front()); rsp_acc = 0; end
      if (req_acc) begin void'(req_q.pop_front()); req_acc = 0; end
      l2_rsp_out_data_coh_msg = 2'($urandom);
      l2_rsp_out_data_req_id  = CIB'($urandom);
      l2_rsp_out_data_to_req  = 2'($urandom);
      l2_rsp_out_data_addr    = LAB'($urandom);
      l2_rsp_out_data_line    = rnd_line();
      l2_req_out_data_coh_msg = 2'($urandom);
      l2_req_out_data_hprot   = 2'($urandom);
      l2_req_out_data_addr    = LAB'($urandom);
      l2_req_out_data_line    = rnd_line();
      l2_rsp_out_valid = (rsp_q.size() != 0);
      if (l2_rsp_out_valid) begin
        cur_rsp = rsp_q[0];
        l2_rsp_out_data_coh_msg = cur_rsp.coh;
        l2_rsp_out_data_req_id  = cur_rsp.id;
        l2_rsp_out_data_to_req  = cur_rsp.f2;
        l2_rsp_out_data_addr    = cur_rsp.addr;
        l2_rsp_out_data_line    = cur_rsp.line;
      end
      l2_req_out_valid = (req_q.size() != 0);
      if (l2_req_out_valid) begin
        cur_req = req_q[0];
        l2_req_out_data_coh_msg = cur_req.coh;
        l2_req_out_data_hprot   = cur_req.f2;
        l2_req_out_data_addr    = cur_req.addr;
        l2_req_out_data_line    = cur_req.line;
      end
    end
  end

  // Monitor / scoreboard on the falling edge.
  initial begin
    bit            prev_hold = 0;
    logic [WB-1:0] prev_data;
    bit            prev_last;
    bit            exp_w;
    flit_t         f;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_valid", WB'(noc_out_valid), '0);
        chk("rst_data", noc_out_data, '0);
        chk("rst_last", WB'(noc_out_last), '0);
        chk("rst_rsp_ready", WB'(l2_rsp_out_ready), '0);
        chk("rst_req_ready", WB'(l2_req_out_ready), '0);
        exp_q.delete();
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", WB'(noc_out_valid), WB'(1));
          chk("hold_data", noc_out_data, prev_data);
          chk("hold_last", WB'(noc_out_last), WB'(prev_last));
        end
        exp_w = !noc_out_valid || (noc_out_ready && exp_q.size() != 0 && exp_q[0].last);
        chk("rsp_ready", WB'(l2_rsp_out_ready), WB'(exp_w));
        chk("req_ready", WB'(l2_req_out_ready), WB'(exp_w && !l2_rsp_out_valid));
        if (count_en && noc_out_valid) begin
          vcycles++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (l2_rsp_out_ready) pulses++;
        end
        if (noc_out_valid && noc_out_ready) begin
          flits_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_flit", noc_out_data, '0);
            if (noc_out_data === '0) begin
              failures++;
              $display("FAIL unexpected_flit actual=valid required=idle");
            end
          end else begin
            f = exp_q.pop_front();
            chk("flit_data", noc_out_data, f.data);
            chk("flit_last", WB'(noc_out_last), WB'(f.last));
          end
        end
        if (l2_rsp_out_valid && l2_rsp_out_ready) begin push_flits(cur_rsp); rsp_acc = 1; end
        if (l2_req_out_valid && l2_req_out_ready) begin push_flits(cur_req); req_acc = 1; end
        prev_hold = noc_out_valid && !noc_out_ready;
        prev_data = noc_out_data;
        prev_last = noc_out_last;
      end
    end
  end

  task automatic drain(input bit rnd);
    int n = 0;
    while ((req_q.size() != 0 || rsp_q.size() != 0 || exp_q.size() != 0 || noc_out_valid) && n < 2000) begin
      @(posedge clk); #2;
      if (rnd) noc_out_ready = ($urandom_range(0, 2) != 0);
      n++;
    end
    noc_out_ready = 1'b1;
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=<2000", n);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    rst = 1'b1;
    noc_out_ready = 1'b1;
    vecs[0] = '{mk(1, 2'd0, 2'd1, 4'd5, 28'h0ABCDEF, {64'hA1A2_A3A4_A5A6_A7A8, 64'h0102_0304_0506_0708}), 3};
    vecs[1] = '{mk(0, 2'd0, 2'd1, 4'd7, 28'h1234567, rnd_line()), 1};
    vecs[2] = '{mk(0, 2'd3, 2'd2, 4'd0, 28'hFFFFFFF, rnd_line()), 3};
    vecs[3] = '{mk(1, 2'd2, 2'd3, 4'd15, 28'h0000001, rnd_line()), 1};
    vecs[4] = '{mk(1, 2'd1, 2'd2, 4'd9, 28'h8000000, rnd_line()), 3};
    vecs[5] = '{mk(0, 2'd2, 2'd0, 4'd3, 28'h5A5A5A5, rnd_line()), 1};
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", WB'(noc_out_valid), '0);

    for (int i = 0; i < 6; i++) begin
      flits_seen = 0;
      if (vecs[i].m.is_rsp) rsp_q.push_back(vecs[i].m);
      else req_q.push_back(vecs[i].m);
      drain(0);
      chk($sformatf("vec%0d_nflits", i), WB'(flits_seen), WB'(vecs[i].nflits));
    end

    // Conflict: rsp INVACK and req PUTM presented together.
    flits_seen = 0;
    rsp_q.push_back(mk(1, 2'd2, 2'd1, 4'd2, 28'h0C0FFEE, rnd_line()));
    req_q.push_back(mk(0, 2'd3, 2'd1, 4'd0, 28'h0BEEF00, rnd_line()));
    drain(0);
    chk("conflict_nflits", WB'(flits_seen), WB'(4));

    // Back-to-back stream of 4 rsp data messages.
    flits_seen = 0; vcycles = 0; pulses = 0; first_cyc = -1; last_cyc = -1;
    count_en = 1;
    for (int i = 0; i < 4; i++) rsp_q.push_back(mk(1, 2'd0, 2'(i), 4'(i), 28'(i * 16 + 3), rnd_line()));
    drain(0);
    count_en = 0;
    chk("stream_valid_cycles", WB'(vcycles), WB'(12));
    chk("stream_span", WB'(last_cyc - first_cyc + 1), WB'(12));
    chk("stream_ready_pulses", WB'(pulses), WB'(4));

    // Sink stalls for 3 cycles in the middle of DATA.
    flits_seen = 0;
    noc_out_ready = 1'b0;
    req_q.push_back(mk(0, 2'd3, 2'd3, 4'd0, 28'h0DDDDDD, rnd_line()));
    n = 0;
    while (req_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("stall_accept_timeout", WB'(n >= 200), '0);
    @(posedge clk); #2 noc_out_ready = 1'b1;
    @(posedge clk); #2 noc_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 noc_out_ready = 1'b1;
    drain(0);
    chk("stall_nflits", WB'(flits_seen), WB'(3));

    // Random backpressure over a mixed burst.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) != 0)
        rsp_q.push_back(mk(1, 2'($urandom), 2'($urandom), 4'($urandom), 28'($urandom), rnd_line()));
      else
        req_q.push_back(mk(0, 2'($urandom), 2'($urandom), 4'($urandom), 28'($urandom), rnd_line()));
    end
    drain(1);

    // Reset during DATA of a PUTM drops the rest of the message.
    noc_out_ready = 1'b0;
    req_q.push_back(mk(0, 2'd3, 2'd0, 4'd0, 28'h0777777, rnd_line()));
    n = 0;
    while (req_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("rst_accept_timeout", WB'(n >= 200), '0);
    @(posedge clk); #2 noc_out_ready = 1'b1;
    @(posedge clk); #2 noc_out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0; noc_out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", WB'(noc_out_valid), '0);
    chk("post_rst_rsp_ready", WB'(l2_rsp_out_ready), WB'(1));
    chk("post_rst_req_ready", WB'(l2_req_out_ready), WB'(1));
    flits_seen = 0;
    rsp_q.push_back(mk(1, 2'd3, 2'd2, 4'd11, 28'h0246802, rnd_line()));
    drain(0);
    chk("post_rst_nflits", WB'(flits_seen), WB'(3));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_coh_out_serializer.md
# l2_coh_out_serializer

Downstream stage of the L2 cache: merges the L2 outgoing coherence request channel (`l2_req_out_*`) and outgoing coherence response channel (`l2_rsp_out_*`) into a single word-wide flit stream toward the NoC plane interface. Each accepted message is buffered once, then emitted as one header flit followed by zero or `WORDS_PER_LINE` data flits. Responses have fixed priority over requests so the coherence protocol can always drain responses.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `LINE_ADDR_BITS`, 28, width of line address.
- `WORD_BITS`, 64, flit and word width. Requires `LINE_ADDR_BITS + 9 <= WORD_BITS`.
- `WORDS_PER_LINE`, 2, words per cache line. `LINE_BITS = WORD_BITS*WORDS_PER_LINE`.
- `CACHE_ID_BITS`, 4, requester id width.
- `REQ_DATA_MSG`, 2'b11, the request coh_msg that carries a line (PUTM).
- `RSP_NODATA_MSG`, 2'b10, the response coh_msg that carries no line (INVACK).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `l2_req_out_valid`  in  1  request valid
- `l2_req_out_data_coh_msg`  in  2  request message type
- `l2_req_out_data_hprot`  in  2  protection bits
- `l2_req_out_data_addr`  in  LINE_ADDR_BITS  line address
- `l2_req_out_data_line`  in  LINE_BITS  line payload
- `l2_req_out_ready`  out  1  request accepted when valid&ready
- `l2_rsp_out_valid`  in  1  response valid
- `l2_rsp_out_data_coh_msg`  in  2  response message type
- `l2_rsp_out_data_req_id`  in  CACHE_ID_BITS  destination cache id
- `l2_rsp_out_data_to_req`  in  2  to-requester flags
- `l2_rsp_out_data_addr`  in  LINE_ADDR_BITS  line address
- `l2_rsp_out_data_line`  in  LINE_BITS  line payload
- `l2_rsp_out_ready`  out  1  response accepted when valid&ready
- `noc_out_valid`  out  1  flit valid
- `noc_out_data`  out  WORD_BITS  flit
- `noc_out_last`  out  1  final flit of message
- `noc_out_ready`  in  1  sink accepts flit

## Operation
- States: IDLE (buffer empty), HDR (header pending), DATA (data flits pending). Internal word counter `widx`, width clog2(WORDS_PER_LINE).
- Acceptance window W = (state==IDLE) or (flit accepted this cycle with `noc_out_last`=1). Outside W both readies are 0.
- In W: `l2_rsp_out_ready`=1; `l2_req_out_ready` = !`l2_rsp_out_valid`. Readies do not depend on `noc_out_ready` except through W.
- Accept: capture all fields of the winning channel plus channel bit (rsp=1, req=0) and has_data flag: req has_data = (coh_msg==REQ_DATA_MSG); rsp has_data = (coh_msg!=RSP_NODATA_MSG). Next state HDR, `widx`=0.
- Header flit: [1:0] coh_msg; [3:2] hprot (req) or to_req (rsp); [4] channel; [4+CACHE_ID_BITS:5] req_id (0 for req); [8+LINE_ADDR_BITS:9] addr; remaining bits 0. `noc_out_last` = !has_data.
- HDR, flit accepted: has_data -> DATA; else -> HDR if new message accepted same cycle, else IDLE.
- DATA: `noc_out_data` = line word `widx` (word 0 = line[WORD_BITS-1:0] first). On accept, `widx`++; `noc_out_last`=1 when `widx`==WORDS_PER_LINE-1; after the last, go to HDR (new capture) or IDLE; `widx` resets to 0.
- `noc_out_valid`=1 in HDR and DATA; `noc_out_data`/`noc_out_last` held stable while valid&!ready.
- Input data is sampled only on the accept cycle; input changes afterward have no effect on the message in flight.

## Timing
- Reset: state IDLE, `widx`=0, buffer cleared; `noc_out_valid`=0, `noc_out_data`=0, `noc_out_last`=0, both readies 0 while `rst`=1. Reset mid-message drops the buffered message; no partial flits are emitted afterward.
- Latency: accept in cycle N -> header valid in cycle N+1.
- Throughput with `noc_out_ready` held 1: 1 flit/cycle, back-to-back messages with no bubble (capture overlaps last flit).
- Simultaneous valid on both channels: rsp wins; req waits, its valid must stay asserted (AXI-style: valid never drops without ready).
- Backpressure: `noc_out_ready`=0 for any number of cycles holds the current flit indefinitely, no duplicate or lost flits.

## Test plan
- Single rsp RSP_DATA (coh_msg 0, req_id 5, to_req 1, addr 0x0ABCDEF, line {W1,W0}), sink always ready -> 3 flits: header (bits [1:0]=0, [3:2]=1, [4]=1, [8:5]=5, addr field 0x0ABCDEF), W0, W1 with last.
- Req GETS (coh_msg 0, hprot 1) -> 1 header flit, `noc_out_last`=1, channel bit 0, req_id field 0.
- Both valid in same cycle (rsp INVACK, req PUTM) -> rsp header alone (last=1) first, then req header + 2 data flits; `l2_req_out_ready`=0 in the conflict cycle.
- Stream of 4 rsp data messages, sink ready -> 12 consecutive valid cycles, no bubble, readies pulse on each last flit.
- Random `noc_out_ready` deassertion (e.g. 0 for 3 cycles mid-DATA) -> flit held stable, final sequence identical to ready-always case.
- Assert `rst` for 1 cycle during DATA of a PUTM -> next cycle `noc_out_valid`=0, readies=1 after reset releases, next message emitted intact.
